// File: rtl/integral_adc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the dual-slope integrating ADC conversion sequencer:
//   - FSM state encoding (3-bit localparam constants)
//   - analog switch drive levels (switches are active-low)
//   - packed switch-group struct and the state -> switch decode function
//   - default timer/result width
// ----------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_AZ        = 3'd1;
    localparam logic [2:0] ST_INTEGRATE = 3'd2;
    localparam logic [2:0] ST_RUNDOWN   = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_DUMP      = 3'd6;

    localparam logic SW_OPEN   = 1'b1;
    localparam logic SW_CLOSED = 1'b0;

    typedef struct packed {
        logic input_charge;
        logic charge;
        logic discharge;
        logic discharge_end;
    } sw_t;

    localparam sw_t SW_ALL_OPEN = '{SW_OPEN, SW_OPEN, SW_OPEN, SW_OPEN};

    // At most one switch group is ever closed; everything else stays open.
    // pol selects the reference that drives the integrator back toward zero.
    function automatic sw_t sw_decode(input logic [2:0] st, input logic pol);
        sw_t s;
        s = SW_ALL_OPEN;
        case (st)
            ST_AZ, ST_DUMP: s.discharge_end = SW_CLOSED;
            ST_INTEGRATE:   s.input_charge  = SW_CLOSED;
            ST_RUNDOWN: begin
                if (pol) s.discharge = SW_CLOSED;
                else     s.charge    = SW_CLOSED;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/integral_adc_sequencer_if.sv
// ----------------------------------------------------------------------------
// integral_adc_sequencer_if
// Bundles the sequencer's request/config inputs, the comparator input, the
// analog switch outputs and the result/status outputs.
//   master : register block / analog model side (drives start, abort, cfg_*,
//            comp; observes switches and results)
//   slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface integral_adc_sequencer_if
    import adc_seq_pkg::*;
    #(parameter int CNT_W = CNT_W_DEF);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_t_az;
    logic [CNT_W-1:0] cfg_t_int;
    logic [CNT_W-1:0] cfg_t_max;
    logic [CNT_W-1:0] cfg_t_hold;
    logic             comp;
    logic             input_charge;
    logic             charge;
    logic             discharge;
    logic             discharge_end;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_sign;
    logic             overrange;
    logic             result_valid;

    modport master (
        output start, abort, cfg_t_az, cfg_t_int, cfg_t_max, cfg_t_hold, comp,
        input  input_charge, charge, discharge, discharge_end,
        input  busy, result, result_sign, overrange, result_valid
    );

    modport slave (
        input  start, abort, cfg_t_az, cfg_t_int, cfg_t_max, cfg_t_hold, comp,
        output input_charge, charge, discharge, discharge_end,
        output busy, result, result_sign, overrange, result_valid
    );

endinterface

// File: rtl/integral_adc_sequencer_comp_sync.sv
// ----------------------------------------------------------------------------
// comp_sync
// Multi-flop synchronizer for the asynchronous integrator comparator.
//   clock  : system clock
//   reset  : asynchronous, active-high; clears the whole chain to 0
//   d_i    : asynchronous comparator level
//   q_o    : synchronized level, SYNC_STAGES cycles behind d_i
// ----------------------------------------------------------------------------
module comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/integral_adc_sequencer.sv
// ----------------------------------------------------------------------------
// integral_adc_sequencer
// Dual-slope integrating ADC conversion sequencer. A start request walks the
// integrator through autozero, fixed-time signal integration, reference
// run-down until the comparator crosses zero (or a timeout), and a hold
// phase, then presents the run-down count with a one-cycle valid strobe.
// An abort dumps the integrator for the autozero length and returns to idle
// without touching the previous result.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/abort requests, cfg_t_az/int/max/hold phase lengths,
//                  async comparator comp, active-low switch drives
//                  input_charge/charge/discharge/discharge_end, busy,
//                  result/result_sign/overrange with result_valid strobe
// ----------------------------------------------------------------------------
module integral_adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    integral_adc_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // A programmed length of 0 still gives a one-cycle phase.
    function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    logic             comp_s;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] az_q, az_d;
    logic [CNT_W-1:0] int_q, int_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pol_q, pol_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             sign_q, sign_d;
    logic             ovr_q, ovr_d;
    sw_t              sw_q, sw_d;

    comp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_comp_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (bus.comp),
        .q_o   (comp_s)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        az_d     = az_q;
        int_d    = int_q;
        max_d    = max_q;
        hold_d   = hold_q;
        pol_d    = pol_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        result_d = result_q;
        sign_d   = sign_q;
        ovr_d    = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_AZ;
                    tmr_d   = '0;
                    busy_d  = 1'b1;
                    az_d    = phase_len(bus.cfg_t_az);
                    int_d   = phase_len(bus.cfg_t_int);
                    max_d   = phase_len(bus.cfg_t_max);
                    hold_d  = phase_len(bus.cfg_t_hold);
                end
            end
            ST_AZ: begin
                if (tmr_q == az_q - ONE) begin
                    state_d = ST_INTEGRATE;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_q + ONE;
                end
            end
            ST_INTEGRATE: begin
                if (tmr_q == int_q - ONE) begin
                    state_d = ST_RUNDOWN;
                    tmr_d   = '0;
                    pol_d   = comp_s;
                end else begin
                    tmr_d   = tmr_q + ONE;
                end
            end
            ST_RUNDOWN: begin
                // Zero crossing takes priority over the timeout on the same cycle.
                if (comp_s != pol_q) begin
                    state_d  = ST_HOLD;
                    tmr_d    = '0;
                    result_d = tmr_q;
                    sign_d   = pol_q;
                    ovr_d    = 1'b0;
                end else if (tmr_q == max_q - ONE) begin
                    state_d  = ST_HOLD;
                    tmr_d    = '0;
                    result_d = max_q;
                    sign_d   = pol_q;
                    ovr_d    = 1'b1;
                end else begin
                    tmr_d    = tmr_q + ONE;
                end
            end
            ST_HOLD: begin
                if (tmr_q == hold_q - ONE) begin
                    state_d = ST_DONE;
                    tmr_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    tmr_d   = tmr_q + ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
                busy_d  = 1'b0;
            end
            ST_DUMP: begin
                if (tmr_q == az_q - ONE) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    tmr_d   = tmr_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides any phase exit decided above and discards a result
        // that would have been latched on this edge.
        if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_DUMP)) begin
            state_d  = ST_DUMP;
            tmr_d    = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
            pol_d    = pol_q;
            result_d = result_q;
            sign_d   = sign_q;
            ovr_d    = ovr_q;
        end

        // Switches are registered from the next state so they move on the
        // same edge as the state register.
        sw_d = sw_decode(state_d, pol_d);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            az_q     <= ONE;
            int_q    <= ONE;
            max_q    <= ONE;
            hold_q   <= ONE;
            pol_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            sign_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sw_q     <= SW_ALL_OPEN;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            az_q     <= az_d;
            int_q    <= int_d;
            max_q    <= max_d;
            hold_q   <= hold_d;
            pol_q    <= pol_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            ovr_q    <= ovr_d;
            sw_q     <= sw_d;
        end
    end

    assign bus.input_charge  = sw_q.input_charge;
    assign bus.charge        = sw_q.charge;
    assign bus.discharge     = sw_q.discharge;
    assign bus.discharge_end = sw_q.discharge_end;
    assign bus.busy          = busy_q;
    assign bus.result        = result_q;
    assign bus.result_sign   = sign_q;
    assign bus.overrange     = ovr_q;
    assign bus.result_valid  = valid_q;

endmodule

// File: tb/tb_integral_adc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_integral_adc_sequencer
// Directed bench for integral_adc_sequencer: normal conversion, timeout,
// abort, reset mid-conversion, minimum phase lengths with config capture,
// immediate zero crossing and back-to-back conversions.
// ----------------------------------------------------------------------------
module tb_integral_adc_sequencer;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_mis;
    int   vcount;
    int   v0;

    integral_adc_sequencer_if #(.CNT_W(16)) bus ();

    integral_adc_sequencer #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts cycles in which result_valid is high, sampled mid-cycle.
    initial vcount = 0;
    always @(negedge clock) if (bus.result_valid) vcount++;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sw();
        return {bus.input_charge, bus.charge, bus.discharge, bus.discharge_end};
    endfunction

    task automatic set_cfg(input int az, input int ti, input int tm, input int th);
        bus.cfg_t_az   = 16'(az);
        bus.cfg_t_int  = 16'(ti);
        bus.cfg_t_max  = 16'(tm);
        bus.cfg_t_hold = 16'(th);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.comp  = 1'b1;
        set_cfg(4, 100, 500, 3);

        // Reset state
        tick(2);
        chk("rst_sw",     32'(sw()), 32'hF);
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_valid",  32'(bus.result_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_sign",   32'(bus.result_sign), 0);
        chk("rst_ovr",    32'(bus.overrange), 0);
        reset = 1'b0;
        tick(3);

        // T1: positive input, zero crossing 30 cycles into run-down
        v0 = vcount;
        bus.start = 1'b1;
        tick(1);                                   // E1: AZ
        bus.start = 1'b0;
        chk("t1_az_sw",   32'(sw()), 32'hE);
        chk("t1_busy",    32'(bus.busy), 1);
        tick(3);                                   // E4: last AZ cycle
        chk("t1_az_end",  32'(sw()), 32'hE);
        tick(1);                                   // E5: INTEGRATE
        chk("t1_int_sw",  32'(sw()), 32'h7);
        tick(99);                                  // E104: last INTEGRATE cycle
        chk("t1_int_end", 32'(sw()), 32'h7);
        tick(1);                                   // E105: RUNDOWN, pol=1
        chk("t1_rd_sw",   32'(sw()), 32'hD);
        tick(30);                                  // E135
        bus.comp = 1'b0;
        tick(2);                                   // E137: comp_s now 0
        chk("t1_rd_hold", 32'(sw()), 32'hD);
        tick(1);                                   // E138: HOLD
        chk("t1_hold_sw", 32'(sw()), 32'hF);
        chk("t1_novalid", 32'(bus.result_valid), 0);
        tick(3);                                   // E141: DONE
        chk("t1_valid",   32'(bus.result_valid), 1);
        chk("t1_result",  32'(bus.result), 32);
        chk("t1_sign",    32'(bus.result_sign), 1);
        chk("t1_ovr",     32'(bus.overrange), 0);
        chk("t1_busy_dn", 32'(bus.busy), 1);
        tick(1);                                   // E142: IDLE
        chk("t1_valid_lo", 32'(bus.result_valid), 0);
        chk("t1_idle",    32'(bus.busy), 0);
        chk("t1_pulses",  32'(vcount - v0), 1);

        // T2: comp held low -> charge switch, timeout
        tick(2);
        bus.start = 1'b1;
        tick(1);                                   // E1
        bus.start = 1'b0;
        tick(104);                                 // E105: RUNDOWN, pol=0
        chk("t2_rd_sw",   32'(sw()), 32'hB);
        tick(499);                                 // E604: last RUNDOWN cycle
        chk("t2_rd_end",  32'(sw()), 32'hB);
        tick(1);                                   // E605: HOLD
        chk("t2_hold_sw", 32'(sw()), 32'hF);
        tick(3);                                   // E608: DONE
        chk("t2_valid",   32'(bus.result_valid), 1);
        chk("t2_result",  32'(bus.result), 500);
        chk("t2_ovr",     32'(bus.overrange), 1);
        chk("t2_sign",    32'(bus.result_sign), 0);
        tick(1);
        chk("t2_idle",    32'(bus.busy), 0);

        // T3: abort in INTEGRATE cycle 50, abort held into DUMP (ignored there)
        v0 = vcount;
        bus.start = 1'b1;
        tick(1);                                   // E1
        bus.start = 1'b0;
        tick(54);                                  // E55: INTEGRATE cycle 50
        bus.abort = 1'b1;
        tick(1);                                   // E56: DUMP
        chk("t3_dump_sw", 32'(sw()), 32'hE);
        chk("t3_busy",    32'(bus.busy), 1);
        tick(2);                                   // E58
        bus.abort = 1'b0;
        tick(1);                                   // E59: last DUMP cycle
        chk("t3_dump_end", 32'(sw()), 32'hE);
        chk("t3_busy2",   32'(bus.busy), 1);
        tick(1);                                   // E60: IDLE
        chk("t3_idle_sw", 32'(sw()), 32'hF);
        chk("t3_idle",    32'(bus.busy), 0);
        chk("t3_result",  32'(bus.result), 500);
        chk("t3_ovr",     32'(bus.overrange), 1);
        chk("t3_pulses",  32'(vcount - v0), 0);

        // T4: asynchronous reset mid-RUNDOWN
        bus.comp = 1'b1;
        tick(2);
        bus.start = 1'b1;
        tick(1);                                   // E1
        bus.start = 1'b0;
        tick(114);                                 // E115: RUNDOWN
        chk("t4_rd_sw",   32'(sw()), 32'hD);
        reset = 1'b1;
        #1;
        chk("t4_rst_sw",  32'(sw()), 32'hF);
        chk("t4_rst_busy", 32'(bus.busy), 0);
        chk("t4_rst_res", 32'(bus.result), 0);
        #1;
        reset = 1'b0;

        // T5: minimum phase lengths; cfg changed after start is ignored
        bus.comp = 1'b0;
        set_cfg(0, 0, 3, 0);
        tick(3);
        v0 = vcount;
        bus.start = 1'b1;
        tick(1);                                   // E1: AZ
        bus.start = 1'b0;
        set_cfg(50, 50, 50, 50);
        chk("t5_az_sw",   32'(sw()), 32'hE);
        chk("t5_busy",    32'(bus.busy), 1);
        tick(1);                                   // E2: INTEGRATE
        chk("t5_int_sw",  32'(sw()), 32'h7);
        tick(1);                                   // E3: RUNDOWN
        chk("t5_rd_sw",   32'(sw()), 32'hB);
        tick(2);                                   // E5
        chk("t5_rd_end",  32'(sw()), 32'hB);
        tick(1);                                   // E6: HOLD
        chk("t5_hold_sw", 32'(sw()), 32'hF);
        tick(1);                                   // E7: DONE
        chk("t5_valid",   32'(bus.result_valid), 1);
        chk("t5_result",  32'(bus.result), 3);
        chk("t5_ovr",     32'(bus.overrange), 1);
        tick(1);
        chk("t5_idle",    32'(bus.busy), 0);
        chk("t5_pulses",  32'(vcount - v0), 1);

        // T6: flip on first RUNDOWN cycle; start held -> back-to-back
        set_cfg(1, 4, 20, 1);
        bus.comp = 1'b1;
        tick(3);
        bus.start = 1'b1;
        tick(1);                                   // E1: AZ
        chk("t6_az_sw",   32'(sw()), 32'hE);
        tick(1);                                   // E2: INTEGRATE despite start
        chk("t6_int_sw",  32'(sw()), 32'h7);
        tick(2);                                   // E4
        bus.comp = 1'b0;
        tick(2);                                   // E6: RUNDOWN, pol=1
        chk("t6_rd_sw",   32'(sw()), 32'hD);
        tick(1);                                   // E7: HOLD
        chk("t6_hold_sw", 32'(sw()), 32'hF);
        tick(1);                                   // E8: DONE
        chk("t6_valid",   32'(bus.result_valid), 1);
        chk("t6_result",  32'(bus.result), 0);
        chk("t6_sign",    32'(bus.result_sign), 1);
        chk("t6_ovr",     32'(bus.overrange), 0);
        tick(1);                                   // E9: IDLE
        chk("t6_idle",    32'(bus.busy), 0);
        chk("t6_idle_sw", 32'(sw()), 32'hF);
        tick(1);                                   // E10: AZ again
        bus.start = 1'b0;
        chk("t6_b2b_busy", 32'(bus.busy), 1);
        chk("t6_b2b_sw",  32'(sw()), 32'hE);
        tick(26);                                  // E36: second DONE
        chk("t6_b2b_valid", 32'(bus.result_valid), 1);
        chk("t6_b2b_result", 32'(bus.result), 20);
        chk("t6_b2b_ovr", 32'(bus.overrange), 1);
        chk("t6_b2b_sign", 32'(bus.result_sign), 0);
        tick(1);
        chk("t6_b2b_idle", 32'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
